// File: rtl/conv_pkg.sv
// Shared types and defaults for the convolution sequencer.
package conv_pkg;

    localparam int unsigned SIZE_W_DEF = 5;

    typedef enum logic [2:0] {
        S_IDLE,
        S_SETUP,
        S_ISSUE,
        S_DRAIN,
        S_WRITE,
        S_DONE,
        S_RELEASE,
        S_ERROR
    } conv_state_t;

endpackage

// File: rtl/conv_valid_pipe.sv
// Delay line that turns the read strobe into the product-valid strobe.
module conv_valid_pipe #(
    parameter int unsigned DEPTH = 3
) (
    input  logic clk,
    input  logic rst_n,
    input  logic i_flush,
    input  logic i_din,
    output logic o_dout
);

    logic [DEPTH-1:0] r_sh;

    // Shift one stage per cycle; a flush empties every stage at once.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sh <= '0;
        end else if (i_flush) begin
            r_sh <= '0;
        end else begin
            r_sh[0] <= i_din;
            for (int unsigned j = 1; j < DEPTH; j++) begin
                r_sh[j] <= r_sh[j-1];
            end
        end
    end

    assign o_dout = r_sh[DEPTH-1];

endmodule

// File: rtl/convolutor_seq_ctrl.sv
// Sequencer for a 1-D linear convolution z = x * y: issues X/Y reads,
// steers an external MAC and writes each z[k] once its sum is complete.
module convolutor_seq_ctrl
    import conv_pkg::*;
#(
    parameter int unsigned SIZE_W   = SIZE_W_DEF,
    parameter int unsigned MEM_LAT  = 1,
    parameter int unsigned MULT_LAT = 2
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start_i,
    input  logic              abort_i,
    input  logic [SIZE_W-1:0] size_x_i,
    input  logic [SIZE_W-1:0] size_y_i,
    output logic              rd_en_o,
    output logic [SIZE_W-1:0] x_addr_o,
    output logic [SIZE_W-1:0] y_addr_o,
    output logic              mac_en_o,
    output logic              acc_clr_o,
    output logic              z_we_o,
    output logic [SIZE_W:0]   z_addr_o,
    output logic              busy_o,
    output logic              done_o,
    output logic              err_o
);

    localparam int unsigned LAT = MEM_LAT + MULT_LAT;
    localparam int unsigned KW  = SIZE_W + 1;
    localparam int unsigned CW  = (LAT > 1) ? $clog2(LAT) : 1;

    conv_state_t   r_state;
    conv_state_t   w_state_nxt;

    logic [KW-1:0] r_k;
    logic [KW-1:0] r_i;
    logic [KW-1:0] r_sx;
    logic [KW-1:0] r_sy;
    logic [CW-1:0] r_drain;

    logic [KW-1:0] w_hi;
    logic [KW-1:0] w_k_nxt;
    logic [KW-1:0] w_lo_nxt;
    logic [KW-1:0] w_last_k;
    logic          w_issue_last;
    logic          w_drain_last;
    logic          w_write_last;
    logic          w_busy;
    logic          w_flush;

    // Index bounds: for output k, i runs max(0,k-sy+1) .. min(k,sx-1).
    assign w_hi         = (r_k < r_sx - KW'(1)) ? r_k : r_sx - KW'(1);
    assign w_k_nxt      = r_k + KW'(1);
    assign w_lo_nxt     = (w_k_nxt >= r_sy) ? w_k_nxt - r_sy + KW'(1) : '0;
    assign w_last_k     = r_sx + r_sy - KW'(2);
    assign w_issue_last = (r_i == w_hi);
    assign w_drain_last = (r_drain == CW'(LAT - 1));
    assign w_write_last = (r_k == w_last_k);
    assign w_busy       = (r_state == S_SETUP) || (r_state == S_ISSUE) ||
                          (r_state == S_DRAIN) || (r_state == S_WRITE);
    assign w_flush      = w_busy && abort_i;

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Index and drain counters; each output restarts i at its lower bound.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_k     <= '0;
            r_i     <= '0;
            r_sx    <= '0;
            r_sy    <= '0;
            r_drain <= '0;
        end else begin
            case (r_state)
                S_SETUP: begin
                    r_sx <= {1'b0, size_x_i};
                    r_sy <= {1'b0, size_y_i};
                    r_k  <= '0;
                    r_i  <= '0;
                end
                S_ISSUE: begin
                    if (!w_issue_last) begin
                        r_i <= r_i + KW'(1);
                    end
                end
                S_WRITE: begin
                    if (!w_write_last) begin
                        r_k <= w_k_nxt;
                        r_i <= w_lo_nxt;
                    end
                end
                default: ;
            endcase
            r_drain <= (r_state == S_DRAIN) ? r_drain + CW'(1) : '0;
        end
    end

    // Next-state and output decode; abort from a busy state overrides everything.
    always_comb begin
        w_state_nxt = r_state;
        rd_en_o     = 1'b0;
        acc_clr_o   = 1'b0;
        z_we_o      = 1'b0;
        done_o      = 1'b0;
        err_o       = 1'b0;
        x_addr_o    = '0;
        y_addr_o    = '0;
        z_addr_o    = '0;
        busy_o      = w_busy;

        case (r_state)
            S_IDLE: begin
                if (start_i) w_state_nxt = S_SETUP;
            end
            S_SETUP: begin
                acc_clr_o = 1'b1;
                if ((size_x_i == '0) || (size_y_i == '0)) w_state_nxt = S_ERROR;
                else                                      w_state_nxt = S_ISSUE;
            end
            S_ISSUE: begin
                rd_en_o  = 1'b1;
                x_addr_o = r_i[SIZE_W-1:0];
                y_addr_o = r_k[SIZE_W-1:0] - r_i[SIZE_W-1:0];
                if (w_issue_last) w_state_nxt = S_DRAIN;
            end
            S_DRAIN: begin
                if (w_drain_last) w_state_nxt = S_WRITE;
            end
            S_WRITE: begin
                z_we_o    = 1'b1;
                acc_clr_o = 1'b1;
                z_addr_o  = r_k;
                w_state_nxt = w_write_last ? S_DONE : S_ISSUE;
            end
            S_DONE: begin
                done_o      = 1'b1;
                w_state_nxt = S_RELEASE;
            end
            S_ERROR: begin
                done_o      = 1'b1;
                err_o       = 1'b1;
                w_state_nxt = S_RELEASE;
            end
            S_RELEASE: begin
                if (!start_i) w_state_nxt = S_IDLE;
            end
            default: w_state_nxt = S_IDLE;
        endcase

        if (w_flush) w_state_nxt = S_IDLE;
    end

    conv_valid_pipe #(
        .DEPTH (LAT)
    ) u_valid_pipe (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_flush (w_flush),
        .i_din   (rd_en_o),
        .o_dout  (mac_en_o)
    );

endmodule

// File: doc/convolutor_seq_ctrl.md
CONVOLUTOR_SEQ_CTRL -- requirements
Module: convolutor_seq_ctrl

Interface
REQ-001 Parameter SIZE_W, 5, width of each input vector length; max length 2^SIZE_W-1.
REQ-002 Parameter MEM_LAT, 1, X/Y memory read latency in cycles (>=1).
REQ-003 Parameter MULT_LAT, 2, multiplier pipeline latency in cycles (>=1).
REQ-004 clk  in  1  single clock; all logic on rising edge.
REQ-005 rst_n  in  1  asynchronous, active-low reset.
REQ-006 start_i  in  1  level start request, sampled in IDLE.
REQ-007 abort_i  in  1  cancel current job.
REQ-008 size_x_i, size_y_i  in  SIZE_W each  vector lengths, sampled in SETUP.
REQ-009 rd_en_o  out  1  X/Y memory read strobe.
REQ-010 x_addr_o, y_addr_o  out  SIZE_W each  read addresses.
REQ-011 mac_en_o  out  1  accumulate-enable, aligned with product valid.
REQ-012 acc_clr_o  out  1  accumulator clear.
REQ-013 z_we_o  out  1  Z write strobe.
REQ-014 z_addr_o  out  SIZE_W+1  Z write address.
REQ-015 busy_o, done_o, err_o  out  1 each  status flags.

Function
REQ-016 Computes z[k]=sum x[i]*y[k-i], k=0..SZ-1, SZ=size_x+size_y-1, i from max(0,k-size_y+1) to min(k,size_x-1); SZ held at SIZE_W+1 bits, no overflow.
REQ-017 States: IDLE, SETUP, ISSUE, DRAIN, WRITE, DONE, RELEASE, ERROR.
REQ-018 IDLE -> SETUP when start_i=1; else stay.
REQ-019 SETUP (1 cycle): latch sizes, k=0, acc_clr_o=1; -> ERROR if either size is 0, else -> ISSUE.
REQ-020 ISSUE: one read per cycle, rd_en_o=1, x_addr_o=i, y_addr_o=k-i, i from low to high bound; -> DRAIN in cycle issuing i=high bound.
REQ-021 mac_en_o = rd_en_o delayed exactly MEM_LAT+MULT_LAT cycles (LAT).
REQ-022 DRAIN lasts exactly LAT cycles, then -> WRITE.
REQ-023 WRITE (1 cycle): z_we_o=1, z_addr_o=k, acc_clr_o=1; -> DONE if k=SZ-1, else k+1 and -> ISSUE.
REQ-024 Cycles per output = n_k+LAT+1; total busy = 1 + sum(n_k) + SZ*(LAT+1).
REQ-025 DONE (1 cycle): done_o=1; -> RELEASE.
REQ-026 RELEASE: -> IDLE when start_i=0; start_i held high never restarts a job.
REQ-027 ERROR (1 cycle): err_o=1, done_o=1, no rd_en_o/z_we_o ever asserted; -> RELEASE.
REQ-028 busy_o=1 exactly in SETUP, ISSUE, DRAIN, WRITE; 0 otherwise.
REQ-029 abort_i=1 in any busy state: next state IDLE, delay line flushed, no further mac_en_o, z_we_o, done_o; abort wins over all simultaneous transitions; ignored outside busy states.
REQ-030 All outputs registered from a state/counter register; no combinational path input->output.
REQ-031 rd_en_o, mac_en_o, z_we_o, acc_clr_o never asserted in IDLE, DONE, RELEASE, ERROR (except REQ-021 drain tail, which is empty by construction).

Reset
REQ-032 rst_n low: state IDLE, all counters 0, delay line cleared, every output 0, effective immediately (asynchronous), including mid-job.
REQ-033 First start_i after reset release starts a fresh job with no residual mac_en_o.

Structure
REQ-034 Shared package conv_pkg: state enum conv_state_t and default SIZE_W constant.
REQ-035 One sub-module conv_valid_pipe: parametrised DEPTH shift register with synchronous flush, delays rd_en_o into mac_en_o.

Verification
REQ-036 sx=3, sy=2, MEM_LAT=1, MULT_LAT=2 -> 6 reads (n=1,2,2,1), z_we_o 4 times at addr 0..3, busy_o high 23 cycles, done_o one pulse.
REQ-037 sx=1, sy=1 -> one read at (0,0), mac_en_o 3 cycles later, one write addr 0, busy 6 cycles.
REQ-038 sx=0, sy=4 -> err_o and done_o pulse together 2 cycles after start, zero reads/writes, busy_o 1 cycle (SETUP).
REQ-039 abort_i pulse in 3rd ISSUE cycle of sx=4, sy=4 -> IDLE next cycle, no z_we_o/done_o, mac_en_o drops immediately.
REQ-040 start_i held high through DONE -> single job only; restart only after start_i low then high.
REQ-041 rst_n asserted mid-DRAIN -> all outputs 0 same cycle; new job after release matches REQ-036 counts.
